// File: rtl/tt3_sweep_reader_if.sv
// Host-side start/done handshake and result bus of the 3-input truth-table sweep reader.
interface tt3_sweep_reader_if;
  localparam int unsigned CODE_W = 8;

  logic              start;
  logic [CODE_W-1:0] expected;
  logic              busy;
  logic              done;
  logic [CODE_W-1:0] code;
  logic              match;

  modport master (output start, expected, input busy, done, code, match);
  modport slave  (input start, expected, output busy, done, code, match);
endinterface

// File: rtl/tt3_sweep_reader.sv
// Walks a 3-input block through all eight rows, samples each after a settle time,
// and assembles the hex truth-table code plus a match flag against an expected code.
module tt3_sweep_reader #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tt3_sweep_reader_if.slave   host,
  input  logic                dut_out,
  output logic                drv_in1,
  output logic                drv_in2,
  output logic                drv_in3
);

  localparam int unsigned CODE_W   = 8;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned SETTLE_W = 8;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST    = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [CODE_W-1:0]   exp_q, exp_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ROW_W-1:0]    drv_q, drv_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                match_q, match_d;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    code_d   = code_q;
    match_d  = match_q;

    case (state_q)
      IDLE: begin
        if (host.start) begin
          exp_d    = host.expected;
          row_d    = '0;
          settle_d = '0;
          shadow_d = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        // Row 0 is shifted in first, so it ends up in the MSB after eight samples.
        shadow_d = {shadow_q[CODE_W-2:0], dut_out};
        if (row_q == ROW_LAST) begin
          state_d = FINISH;
        end else begin
          row_d    = row_q + ROW_W'(1);
          settle_d = '0;
          state_d  = DRIVE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    drv_d  = busy_d ? row_d : '0;
    done_d = (state_d == FINISH);
    if (state_d == FINISH) begin
      code_d  = shadow_d;
      match_d = (shadow_d == exp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      settle_q <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drv_q    <= '0;
      code_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drv_q    <= drv_d;
      code_q   <= code_d;
      match_q  <= match_d;
    end
  end

  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.code  = code_q;
  assign host.match = match_q;
  assign {drv_in1, drv_in2, drv_in3} = drv_q;

endmodule
